// File: rtl/freq_pkg.sv
// Shared types and helpers for the frequency-measurement blocks.
package freq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SYNC_WAIT,
        MEASURE,
        DIVIDE,
        STORE
    } state_e;

    localparam int unsigned CLK_FREQ_DEF = 25_000_000;

    // Clamp an unsigned value to the largest number representable in 'width' bits.
    function automatic logic [63:0] saturate(input logic [63:0] value, input int unsigned width);
        logic [63:0] max_v;
        max_v = (64'd1 << width) - 64'd1;
        return (value > max_v) ? max_v : value;
    endfunction

endpackage

// File: rtl/freq_div_seq.sv
// Restoring unsigned divider, one quotient bit per cycle.
// done pulses exactly CNT_W+1 cycles after start; quot holds until the next start.
module freq_div_seq #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [CNT_W-1:0] num,
    input  logic [CNT_W-1:0] den,
    output logic [CNT_W-1:0] quot,
    output logic             done
);

    localparam int unsigned StepW = $clog2(CNT_W + 1);

    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] den_q, den_d;
    logic [StepW-1:0] step_q, step_d;
    logic             done_q, done_d;
    logic [CNT_W:0]   rem_shift;
    logic [CNT_W:0]   rem_sub;

    // One shift/subtract step per cycle; a new start restarts even a running division.
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        den_d     = den_q;
        step_d    = step_q;
        done_d    = 1'b0;
        rem_shift = {rem_q, quo_q[CNT_W-1]};
        rem_sub   = rem_shift - {1'b0, den_q};
        if (start) begin
            rem_d  = '0;
            quo_d  = num;
            den_d  = den;
            step_d = StepW'(CNT_W);
        end else if (step_q != '0) begin
            // Sign bit of the trial subtraction decides the quotient bit.
            if (!rem_sub[CNT_W]) begin
                rem_d = rem_sub[CNT_W-1:0];
                quo_d = {quo_q[CNT_W-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[CNT_W-1:0];
                quo_d = {quo_q[CNT_W-2:0], 1'b0};
            end
            step_d = step_q - StepW'(1);
            done_d = (step_q == StepW'(1));
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            step_q <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            den_q  <= den_d;
            step_q <= step_d;
            done_q <= done_d;
        end
    end

    assign quot = quo_q;
    assign done = done_q;

endmodule

// File: rtl/freq_scan_ctrl.sv
// Round-robin frequency scanner: one period counter and one divider shared across N_CH inputs.
module freq_scan_ctrl
    import freq_pkg::*;
#(
    parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned FREQ_W   = 19,
    parameter int unsigned TIMEOUT  = 25_000_000,
    parameter int unsigned SETTLE   = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_CH-1:0]   test_in,
    input  logic              en,
    input  logic [N_CH-1:0]   ch_mask,
    output logic              res_valid,
    output logic [2:0]        res_ch,
    output logic [FREQ_W-1:0] res_freq,
    output logic              res_timeout,
    output logic              busy,
    output logic [2:0]        cur_ch
);

    state_e            state_q, state_d;
    logic [N_CH-1:0]   sync1_q, sync2_q;
    logic              edge_q, edge_d;
    logic [2:0]        cur_ch_q, cur_ch_d;
    logic [7:0]        blank_q, blank_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              div_start_q, div_start_d;
    logic              res_valid_q, res_valid_d;
    logic [2:0]        res_ch_q, res_ch_d;
    logic [FREQ_W-1:0] res_freq_q, res_freq_d;
    logic              res_timeout_q, res_timeout_d;

    logic [7:0]        mask_pad;
    logic [7:0]        sync_pad;
    logic              sel_bit;
    logic              rise;
    logic              timed_out;
    logic [2:0]        next_ch;
    logic              next_found;
    logic [3:0]        idx;
    logic [CNT_W-1:0]  div_quot;
    logic              div_done;

    // Zero-pad to the 8-channel index space so a 3-bit channel index is always in range.
    assign mask_pad  = 8'(ch_mask);
    assign sync_pad  = 8'(sync2_q);
    assign sel_bit   = sync_pad[cur_ch_q];
    assign rise      = sel_bit & ~edge_q;
    assign timed_out = (tcnt_q == CNT_W'(TIMEOUT - 1));

    // Synchronizer bank runs continuously on every input.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= test_in;
            sync2_q <= sync1_q;
        end
    end

    // Next enabled channel strictly after cur_ch, wrapping; lands on cur_ch if it is the only one.
    always_comb begin
        next_ch    = cur_ch_q;
        next_found = 1'b0;
        idx        = '0;
        for (int i = 1; i <= int'(N_CH); i++) begin
            idx = {1'b0, cur_ch_q} + 4'(i);
            if (idx >= 4'(N_CH)) begin
                idx = idx - 4'(N_CH);
            end
            if (!next_found && mask_pad[idx[2:0]]) begin
                next_ch    = idx[2:0];
                next_found = 1'b1;
            end
        end
    end

    // Controller next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        edge_d        = sel_bit;
        cur_ch_d      = cur_ch_q;
        blank_d       = blank_q;
        cnt_d         = cnt_q;
        tcnt_d        = tcnt_q;
        period_d      = period_q;
        div_start_d   = 1'b0;
        res_valid_d   = 1'b0;
        res_ch_d      = res_ch_q;
        res_freq_d    = res_freq_q;
        res_timeout_d = res_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (en && (ch_mask != '0)) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (ch_mask == '0) begin
                    state_d = IDLE;
                end else begin
                    cur_ch_d = next_ch;
                    blank_d  = 8'(SETTLE);
                    tcnt_d   = '0;
                    state_d  = SYNC_WAIT;
                end
            end
            SYNC_WAIT: begin
                if (timed_out) begin
                    state_d = STORE;
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                    if (blank_q != '0) begin
                        blank_d = blank_q - 8'd1;
                    end else if (rise) begin
                        cnt_d   = CNT_W'(1);
                        state_d = MEASURE;
                    end
                end
            end
            MEASURE: begin
                if (timed_out) begin
                    state_d = STORE;
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                    if (rise) begin
                        period_d    = cnt_q;
                        div_start_d = 1'b1;
                        state_d     = DIVIDE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DIVIDE: begin
                // A done coinciding with our own start belongs to an earlier, aborted division.
                if (!div_start_q && div_done) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                state_d = (en && (ch_mask != '0)) ? SELECT : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Result registers are loaded on the transition into STORE.
        if (state_d == STORE && state_q != STORE) begin
            res_valid_d = 1'b1;
            res_ch_d    = cur_ch_q;
            if (state_q == DIVIDE) begin
                res_freq_d    = FREQ_W'(saturate(64'(div_quot), FREQ_W));
                res_timeout_d = 1'b0;
            end else begin
                res_freq_d    = '0;
                res_timeout_d = 1'b1;
            end
        end

        // Dropping en abandons any in-flight measurement without a result.
        if (!en && (state_q == SYNC_WAIT || state_q == MEASURE || state_q == DIVIDE)) begin
            state_d       = IDLE;
            div_start_d   = 1'b0;
            res_valid_d   = 1'b0;
            res_ch_d      = res_ch_q;
            res_freq_d    = res_freq_q;
            res_timeout_d = res_timeout_q;
        end
    end

    // Controller state and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            edge_q        <= 1'b0;
            cur_ch_q      <= 3'(N_CH - 1);
            blank_q       <= '0;
            cnt_q         <= '0;
            tcnt_q        <= '0;
            period_q      <= '0;
            div_start_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_ch_q      <= '0;
            res_freq_q    <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            edge_q        <= edge_d;
            cur_ch_q      <= cur_ch_d;
            blank_q       <= blank_d;
            cnt_q         <= cnt_d;
            tcnt_q        <= tcnt_d;
            period_q      <= period_d;
            div_start_q   <= div_start_d;
            res_valid_q   <= res_valid_d;
            res_ch_q      <= res_ch_d;
            res_freq_q    <= res_freq_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    freq_div_seq #(
        .CNT_W(CNT_W)
    ) u_div (
        .clk  (clk),
        .rstn (rstn),
        .start(div_start_q),
        .num  (CNT_W'(CLK_FREQ)),
        .den  (period_q),
        .quot (div_quot),
        .done (div_done)
    );

    assign res_valid   = res_valid_q;
    assign res_ch      = res_ch_q;
    assign res_freq    = res_freq_q;
    assign res_timeout = res_timeout_q;
    assign busy        = (state_q != IDLE);
    assign cur_ch      = cur_ch_q;

endmodule

// File: tb/tb_freq_scan_ctrl.sv
// Directed bench for freq_scan_ctrl: single channel, round-robin, saturation, timeout,
// abort and reset-during-divide.
module tb_freq_scan_ctrl;
    import freq_pkg::*;

    logic        clk;
    logic        rstn;
    logic [3:0]  test_in;
    logic        en, en2;
    logic [3:0]  ch_mask, ch_mask2;
    logic        res_valid, res_timeout, busy;
    logic [2:0]  res_ch, cur_ch;
    logic [18:0] res_freq;
    logic        res_valid2, res_timeout2, busy2;
    logic [2:0]  res_ch2, cur_ch2;
    logic [18:0] res_freq2;

    int total = 0;
    int bad   = 0;
    int per [4];
    int ph  [4];

    freq_scan_ctrl #(
        .CLK_FREQ(25_000_000), .N_CH(4), .CNT_W(32), .FREQ_W(19), .TIMEOUT(8000), .SETTLE(3)
    ) u_dut (
        .clk(clk), .rstn(rstn), .test_in(test_in), .en(en), .ch_mask(ch_mask),
        .res_valid(res_valid), .res_ch(res_ch), .res_freq(res_freq),
        .res_timeout(res_timeout), .busy(busy), .cur_ch(cur_ch)
    );

    freq_scan_ctrl #(
        .CLK_FREQ(25_000_000), .N_CH(4), .CNT_W(32), .FREQ_W(19), .TIMEOUT(1000), .SETTLE(3)
    ) u_dut_to (
        .clk(clk), .rstn(rstn), .test_in(test_in), .en(en2), .ch_mask(ch_mask2),
        .res_valid(res_valid2), .res_ch(res_ch2), .res_freq(res_freq2),
        .res_timeout(res_timeout2), .busy(busy2), .cur_ch(cur_ch2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Test-signal generator: channel ch is a square wave of per[ch] clocks, or held low if 0.
    initial begin
        test_in = '0;
        for (int c = 0; c < 4; c++) ph[c] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < 4; c++) begin
                if (per[c] == 0) begin
                    test_in[c] = 1'b0;
                end else begin
                    ph[c] = ph[c] + 1;
                    if (ph[c] >= per[c]) ph[c] = 0;
                    test_in[c] = (ph[c] < per[c] / 2);
                end
            end
        end
    end

    task automatic do_reset();
        rstn     = 1'b0;
        en       = 1'b0;
        en2      = 1'b0;
        ch_mask  = '0;
        ch_mask2 = '0;
        for (int c = 0; c < 4; c++) per[c] = 0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic wait_res(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_state(input state_e st, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (u_dut.state_q == st) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0d want 0", res_valid); end
        total++; if (res_freq !== 19'd0) begin bad++; $display("FAIL reset_freq: got %0d want 0", res_freq); end
        total++; if (res_ch !== 3'd0) begin bad++; $display("FAIL reset_ch: got %0d want 0", res_ch); end
        total++; if (res_timeout !== 1'b0) begin bad++; $display("FAIL reset_to: got %0d want 0", res_timeout); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0d want 0", busy); end
        total++; if (cur_ch !== 3'd3) begin bad++; $display("FAIL reset_cur_ch: got %0d want 3", cur_ch); end
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        per[0]  = 250;
        ch_mask = 4'b0001;
        en      = 1'b1;
        for (int n = 0; n < 3; n++) begin
            wait_res(2000, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL single_timeout: got no result want result %0d", n);
            end else if (res_ch !== 3'd0 || res_freq !== 19'd100000 || res_timeout !== 1'b0) begin
                bad++;
                $display("FAIL single_res: got ch=%0d f=%0d to=%0d want ch=0 f=100000 to=0",
                         res_ch, res_freq, res_timeout);
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_ch [4] = '{0, 1, 3, 0};
        int exp_f  [4] = '{25000, 50000, 10000, 25000};
        do_reset();
        per[0]  = 1000;
        per[1]  = 500;
        per[3]  = 2500;
        ch_mask = 4'b1011;
        en      = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wait_res(8000, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL rr_wait: got no result want ch=%0d", exp_ch[n]);
            end else if (res_ch !== 3'(exp_ch[n]) || res_freq !== 19'(exp_f[n]) ||
                         res_timeout !== 1'b0) begin
                bad++;
                $display("FAIL rr_res%0d: got ch=%0d f=%0d to=%0d want ch=%0d f=%0d to=0",
                         n, res_ch, res_freq, res_timeout, exp_ch[n], exp_f[n]);
            end
        end
    endtask

    task automatic test_saturate();
        bit ok;
        do_reset();
        per[2]  = 10;
        ch_mask = 4'b0100;
        en      = 1'b1;
        wait_res(500, ok);
        total++;
        if (!ok || res_ch !== 3'd2 || res_freq !== 19'd524287 || res_timeout !== 1'b0) begin
            bad++;
            $display("FAIL saturate: got ok=%0d ch=%0d f=%0d to=%0d want ch=2 f=524287 to=0",
                     ok, res_ch, res_freq, res_timeout);
        end
    endtask

    task automatic test_timeout();
        int  cyc;
        bit  seen;
        do_reset();
        ch_mask2 = 4'b0010;
        en2      = 1'b1;
        seen     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy2) begin seen = 1'b1; break; end
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL to_select: got busy=0 want busy=1");
        end else begin
            // First busy cycle is SELECT; count cycles to the strobe.
            cyc = 0;
            for (int i = 0; i < 1500; i++) begin
                @(negedge clk);
                cyc++;
                if (res_valid2) break;
            end
            total++;
            if (cyc !== 1001) begin bad++; $display("FAIL to_latency: got %0d want 1001", cyc); end
            total++;
            if (res_valid2 !== 1'b1 || res_ch2 !== 3'd1 || res_freq2 !== 19'd0 ||
                res_timeout2 !== 1'b1) begin
                bad++;
                $display("FAIL to_res: got v=%0d ch=%0d f=%0d to=%0d want v=1 ch=1 f=0 to=1",
                         res_valid2, res_ch2, res_freq2, res_timeout2);
            end
            cyc = 0;
            for (int i = 0; i < 1500; i++) begin
                @(negedge clk);
                cyc++;
                if (res_valid2) break;
            end
            total++;
            if (cyc !== 1002) begin bad++; $display("FAIL to_repeat: got %0d want 1002", cyc); end
        end
        en2 = 1'b0;
    endtask

    task automatic test_abort();
        bit ok;
        int nvalid;
        logic busy_late;
        do_reset();
        per[0]  = 1000;
        per[1]  = 500;
        ch_mask = 4'b0011;
        en      = 1'b1;
        wait_state(MEASURE, 3000, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL abort_reach: got no MEASURE want MEASURE");
        end else begin
            repeat (100) @(posedge clk);
            #1 en = 1'b0;
            nvalid    = 0;
            busy_late = 1'b1;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (res_valid) nvalid++;
                if (i == 2) busy_late = busy;
            end
            total++;
            if (busy_late !== 1'b0) begin bad++; $display("FAIL abort_busy: got %0d want 0", busy_late); end
            total++;
            if (nvalid != 0) begin bad++; $display("FAIL abort_novalid: got %0d want 0", nvalid); end
            total++;
            if (cur_ch !== 3'd0) begin bad++; $display("FAIL abort_cur_ch: got %0d want 0", cur_ch); end
            @(posedge clk);
            #1 en = 1'b1;
            wait_res(3000, ok);
            total++;
            if (!ok || res_ch !== 3'd1 || res_freq !== 19'd50000) begin
                bad++;
                $display("FAIL abort_resume: got ok=%0d ch=%0d f=%0d want ch=1 f=50000",
                         ok, res_ch, res_freq);
            end
        end
    endtask

    task automatic test_reset_in_divide();
        bit ok;
        do_reset();
        per[1]  = 500;
        per[2]  = 1000;
        ch_mask = 4'b0110;
        en      = 1'b1;
        wait_res(3000, ok);
        total++;
        if (!ok || res_ch !== 3'd1 || res_freq !== 19'd50000) begin
            bad++;
            $display("FAIL rstdiv_first: got ok=%0d ch=%0d f=%0d want ch=1 f=50000", ok, res_ch, res_freq);
        end
        wait_state(DIVIDE, 4000, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL rstdiv_reach: got no DIVIDE want DIVIDE");
        end else begin
            rstn = 1'b0;
            #1;
            total++;
            if (res_valid !== 1'b0 || res_freq !== 19'd0 || res_ch !== 3'd0 ||
                res_timeout !== 1'b0 || busy !== 1'b0 || cur_ch !== 3'd3) begin
                bad++;
                $display("FAIL rstdiv_outs: got v=%0d f=%0d ch=%0d to=%0d busy=%0d cur=%0d want 0 0 0 0 0 3",
                         res_valid, res_freq, res_ch, res_timeout, busy, cur_ch);
            end
            repeat (2) @(posedge clk);
            #1 rstn = 1'b1;
            wait_res(3000, ok);
            total++;
            if (!ok || res_ch !== 3'd1 || res_freq !== 19'd50000 || res_timeout !== 1'b0) begin
                bad++;
                $display("FAIL rstdiv_after: got ok=%0d ch=%0d f=%0d want ch=1 f=50000", ok, res_ch, res_freq);
            end
        end
    endtask

    initial begin
        for (int c = 0; c < 4; c++) per[c] = 0;
        rstn = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_saturate();
        test_timeout();
        test_abort();
        test_reset_in_divide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freq_scan_ctrl.md
# freq_scan_ctrl

Multi-channel frequency-measurement scheduler. Shares one period counter and one sequential divider across N_CH asynchronous test inputs, scanning enabled channels round-robin. Each channel gets a full rising-to-rising period measurement, converted to Hz as CLK_FREQ / period, and emitted as a one-cycle result strobe. Sits between the raw test pins and the display/UART reporting logic.

## Interface
- CLK_FREQ, 25_000_000: clk frequency in Hz; the division numerator.
- N_CH, 4: number of test inputs, 2..8.
- CNT_W, 32: period counter and divider width.
- FREQ_W, 19: result width; quotient saturates to 2^FREQ_W-1.
- TIMEOUT, 25_000_000: max cycles spent per channel, counted from entering SYNC_WAIT.
- SETTLE, 3: edge-blanking cycles after a channel switch.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- test_in  in  N_CH  asynchronous test signals.
- en  in  1  scan enable, level.
- ch_mask  in  N_CH  channel enable mask, sampled in SELECT.
- res_valid  out  1  one-cycle result strobe.
- res_ch  out  3  channel index of the result.
- res_freq  out  FREQ_W  frequency in Hz; 0 on timeout.
- res_timeout  out  1  result came from a timeout.
- busy  out  1  high in any state except IDLE.
- cur_ch  out  3  channel currently selected.

## Operation
- Every test_in bit passes through a 2-flop synchronizer, always running. The selected bit feeds one extra flop. A rise pulse fires when that flop is 0 and the synchronized value is 1.
- IDLE: when en=1 and ch_mask≠0, go to SELECT.
- SELECT, 1 cycle:
  - cur_ch becomes the next set mask bit strictly after cur_ch, wrapping.
  - If cur_ch's own bit is the only set bit, the same channel is reselected.
  - Loads the blanking counter with SETTLE and clears the timeout counter. Go to SYNC_WAIT.
- SYNC_WAIT: rise pulses are ignored while blanking>0. The first unblanked rise sets cnt=1 and moves to MEASURE.
- MEASURE: cnt increments each cycle. On the next rise, P=cnt is latched and the state goes to DIVIDE.
- Timeout counter: increments in SYNC_WAIT and MEASURE. When it reaches TIMEOUT-1, go to STORE with timeout=1 and freq=0.
- DIVIDE: start pulse to the divider, then wait for done.
- STORE, 1 cycle:
  - res_valid=1.
  - res_freq = min(quotient, 2^FREQ_W-1), or 0 on timeout.
  - res_ch=cur_ch, res_timeout set accordingly.
  - Next state: SELECT if en=1 and ch_mask≠0, else IDLE.
- en=0 in SYNC_WAIT, MEASURE or DIVIDE aborts to IDLE next cycle, with no result. The divider is allowed to finish internally and its done is ignored.
- A mask change mid-measurement does not affect the current channel. It takes effect at the next SELECT.
- Arithmetic: unsigned floor division. P≥2 is guaranteed by synchronization. The quotient is CNT_W bits before saturation.

## Timing
- Reset values:
  - res_valid=0, res_freq=0, res_ch=0, res_timeout=0.
  - busy=0, cur_ch=N_CH-1, so that the first SELECT picks the lowest set bit from channel 0 upward.
  - All counters, synchronizers and state are cleared; state is IDLE.
- Synchronizer plus edge flop: a test_in rising edge produces rise 3 clk later, ±1 for metastability.
- Divider latency is exactly CNT_W+1 cycles from start to done.
- res_valid asserts CNT_W+3 cycles after the rise that ends MEASURE: 1 cycle to DIVIDE, CNT_W+1 divide, 1 to STORE.
- Per-channel overhead beyond the measured signal: SELECT 1 + SETTLE + divide path.
- Timeout result: res_valid exactly TIMEOUT+1 cycles after SELECT.
- res_* hold their values until the next STORE. Only res_valid pulses.

## Structure
- Shared package freq_pkg holds:
  - state enum {IDLE, SELECT, SYNC_WAIT, MEASURE, DIVIDE, STORE};
  - CLK_FREQ default;
  - the saturate function.
- Sub-module freq_div_seq: restoring divider, CNT_W parameter. Ports clk, rstn, start, num, den, quot, done. It is reused by future ratio-measurement blocks.
- Synchronizer bank and controller FSM live in freq_scan_ctrl.

## Test plan
- ch_mask=4'b0001, channel 0 period 250 clk, en=1 → res_ch=0, res_freq=100000, res_timeout=0, repeating every measurement.
- ch_mask=4'b1011, periods ch0=1000, ch1=500, ch3=2500 → results in order ch0 25000, ch1 50000, ch3 10000, then wrapping to ch0.
- Channel 2 period 10 clk, ch_mask=4'b0100 → res_freq=524287 (saturated).
- Channel 1 held constant, TIMEOUT=1000, ch_mask=4'b0010 → res_valid 1001 cycles after SELECT, res_freq=0, res_timeout=1.
- en dropped mid-MEASURE → busy=0 two cycles later, no res_valid. Re-enabling → scan resumes from the channel after the aborted one.
- rstn asserted during DIVIDE → all outputs are 0 and cur_ch=N_CH-1 immediately. After release, the first result comes from the lowest set mask bit.
